// File: rtl/ov7670_capture_pkg.sv
// Shared types and constants for the OV7670 pixel-capture stage.
// State encodings, default frame geometry and pixel-format widths.
package ov7670_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_CAPTURE = 2'd2
  } cap_state_t;

  localparam int DEF_H_ACTIVE    = 640;
  localparam int DEF_V_ACTIVE    = 480;
  localparam int DEF_ADDR_W      = 19;
  localparam int DEF_SYNC_STAGES = 2;

  localparam int LINE_W = 16;
  localparam int BYTE_W = 8;
  localparam int PIX_W  = 16;

  function automatic int frame_pixels(input int h, input int v);
    return h * v;
  endfunction

endpackage

// File: rtl/ov7670_capture_sync_edge.sv
// N-stage synchronizer for one asynchronous camera signal, with
// rise/fall detection on the synchronized output.
module ov7670_capture_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_chain;
  logic              r_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_chain <= '0;
      r_prev  <= 1'b0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_async};
      r_prev  <= r_chain[STAGES-1];
    end
  end

  assign o_sync = r_chain[STAGES-1];
  assign o_rise = r_chain[STAGES-1] & ~r_prev;
  assign o_fall = ~r_chain[STAGES-1] & r_prev;

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 parallel-bus capture: synchronizes the camera pins into clk, pairs
// bytes into RGB565 pixels with linear addresses, and checks frame geometry.
module ov7670_capture
  import ov7670_capture_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              config_finished,
  input  logic              cam_pclk,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [BYTE_W-1:0] cam_d,
  output logic              pix_valid,
  output logic [PIX_W-1:0]  pix_data,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              frame_done,
  output logic              frame_err,
  output cap_state_t        dbg_state
);

  localparam logic [ADDR_W:0] LP_TOTAL = (ADDR_W+1)'(frame_pixels(H_ACTIVE, V_ACTIVE));
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [LINE_W-1:0] LP_V   = LINE_W'(V_ACTIVE);
  localparam logic [LINE_W-1:0] LINE_ONE = LINE_W'(1);

  // Synchronized camera inputs; all share the same depth so they stay aligned.
  logic w_pclk_sync, w_pclk_rise, w_pclk_fall;
  logic w_href_sync, w_href_rise, w_href_fall;
  logic w_vs_sync, w_vs_rise, w_vs_fall;
  logic [BYTE_W-1:0] r_d_sync [SYNC_STAGES];
  logic [BYTE_W-1:0] w_d;
  logic w_unused;

  ov7670_capture_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_pclk (
    .i_clk(clk), .i_rst(clr), .i_async(cam_pclk),
    .o_sync(w_pclk_sync), .o_rise(w_pclk_rise), .o_fall(w_pclk_fall)
  );

  ov7670_capture_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_href (
    .i_clk(clk), .i_rst(clr), .i_async(cam_href),
    .o_sync(w_href_sync), .o_rise(w_href_rise), .o_fall(w_href_fall)
  );

  ov7670_capture_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_vsync (
    .i_clk(clk), .i_rst(clr), .i_async(cam_vsync),
    .o_sync(w_vs_sync), .o_rise(w_vs_rise), .o_fall(w_vs_fall)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_d_sync[i] <= '0;
    end else begin
      r_d_sync[0] <= cam_d;
      for (int i = 1; i < SYNC_STAGES; i++) r_d_sync[i] <= r_d_sync[i-1];
    end
  end

  assign w_d      = r_d_sync[SYNC_STAGES-1];
  assign w_unused = ^{w_pclk_sync, w_pclk_fall, w_href_rise, w_vs_sync};

  // Frame FSM
  cap_state_t r_state, w_next;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (config_finished) w_next = ST_WAIT_VS;
      ST_WAIT_VS: if (w_vs_fall) w_next = ST_CAPTURE;
      ST_CAPTURE: w_next = ST_CAPTURE;
      default:    w_next = ST_IDLE;
    endcase
    if (!config_finished) w_next = ST_IDLE;
  end

  assign dbg_state = r_state;

  // Gating on config_finished too makes an abort take effect the same cycle.
  logic w_capturing;
  assign w_capturing = (r_state == ST_CAPTURE) && config_finished;

  // Datapath: byte pairing -> emit stage -> frame-end stage.
  logic              r_phase;
  logic [BYTE_W-1:0] r_hi;
  logic              r_pend;
  logic [PIX_W-1:0]  r_pend_data;
  logic [ADDR_W:0]   r_cnt;
  logic [LINE_W-1:0] r_line;
  logic              r_err;
  logic              r_vs_end;
  logic              r_vs_end2;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_phase     <= 1'b0;
      r_hi        <= '0;
      r_pend      <= 1'b0;
      r_pend_data <= '0;
      r_cnt       <= '0;
      r_line      <= '0;
      r_err       <= 1'b0;
      r_vs_end    <= 1'b0;
      r_vs_end2   <= 1'b0;
      pix_valid   <= 1'b0;
      pix_data    <= '0;
      pix_addr    <= '0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
    end else if (!w_capturing) begin
      r_phase    <= 1'b0;
      r_pend     <= 1'b0;
      r_cnt      <= '0;
      r_line     <= '0;
      r_err      <= 1'b0;
      r_vs_end   <= 1'b0;
      r_vs_end2  <= 1'b0;
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
      r_pend     <= 1'b0;
      r_vs_end   <= w_vs_rise;
      r_vs_end2  <= r_vs_end;

      if (w_pclk_rise && w_href_sync) begin
        if (!r_phase) begin
          r_hi    <= w_d;
          r_phase <= 1'b1;
        end else begin
          r_phase <= 1'b0;
          if (r_cnt == LP_TOTAL) begin
            r_err <= 1'b1;
          end else begin
            r_pend      <= 1'b1;
            r_pend_data <= {r_hi, w_d};
          end
        end
      end else if (w_href_fall) begin
        if (r_line != '1) r_line <= r_line + LINE_ONE;
        // A dangling first byte at end of line cannot form a pixel.
        if (r_phase) begin
          r_phase <= 1'b0;
          r_err   <= 1'b1;
        end
      end

      if (r_pend) begin
        pix_valid <= 1'b1;
        pix_data  <= r_pend_data;
        pix_addr  <= r_cnt[ADDR_W-1:0];
        r_cnt     <= r_cnt + CNT_ONE;
      end

      // Frame end lags the pixel pipeline so an in-flight pixel is counted first.
      if (r_vs_end2) begin
        frame_done <= 1'b1;
        frame_err  <= (r_cnt != LP_TOTAL) | (r_line != LP_V) | r_err;
        r_cnt      <= '0;
        r_line     <= '0;
        r_phase    <= 1'b0;
        r_err      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ov7670_capture.sv
// Directed bench for ov7670_capture using a 4x2 frame geometry and a
// byte-level camera bus driver.
module tb_ov7670_capture;
  import ov7670_capture_pkg::*;

  localparam int TB_H      = 4;
  localparam int TB_V      = 2;
  localparam int TB_ADDR_W = 3;
  localparam int TB_SYNC   = 2;

  logic                 clk;
  logic                 clr;
  logic                 config_finished;
  logic                 cam_pclk;
  logic                 cam_vsync;
  logic                 cam_href;
  logic [7:0]           cam_d;
  logic                 pix_valid;
  logic [15:0]          pix_data;
  logic [TB_ADDR_W-1:0] pix_addr;
  logic                 frame_done;
  logic                 frame_err;
  cap_state_t           dbg_state;

  ov7670_capture #(
    .H_ACTIVE(TB_H), .V_ACTIVE(TB_V), .ADDR_W(TB_ADDR_W), .SYNC_STAGES(TB_SYNC)
  ) dut (
    .clk(clk), .clr(clr), .config_finished(config_finished),
    .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_d(cam_d),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_addr(pix_addr),
    .frame_done(frame_done), .frame_err(frame_err), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int byte_idx = 0;
  int second_cyc = 0;

  // Scoreboard storage: observed pixels and the expected queue
  logic [15:0]          obs_data[$];
  logic [TB_ADDR_W-1:0] obs_addr[$];
  int                   obs_cyc[$];
  logic [15:0]          exp_q[$];
  int                   done_cnt = 0;
  logic                 done_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pix_valid) begin
      obs_data.push_back(pix_data);
      obs_addr.push_back(pix_addr);
      obs_cyc.push_back(cyc);
    end
    if (frame_done) begin
      done_cnt = done_cnt + 1;
      done_err = frame_err;
    end
  end

  function automatic logic [7:0] byte_at(input int idx);
    logic [31:0] v;
    v = 32'h12 + 32'(idx) * 32'h22;
    return v[7:0];
  endfunction

  // Driver tasks: pclk runs at clk/8, data and href change while pclk is low.
  task automatic send_byte();
    cam_d    = byte_at(byte_idx);
    cam_href = 1'b1;
    repeat (4) @(negedge clk);
    cam_pclk = 1'b1;
    if (byte_idx == 1) second_cyc = cyc;
    repeat (4) @(negedge clk);
    cam_pclk = 1'b0;
    byte_idx = byte_idx + 1;
  endtask

  task automatic idle_pclk(input int n);
    cam_href = 1'b0;
    for (int i = 0; i < n; i++) begin
      repeat (4) @(negedge clk);
      cam_pclk = 1'b1;
      repeat (4) @(negedge clk);
      cam_pclk = 1'b0;
    end
  endtask

  task automatic start_frame();
    cam_vsync = 1'b1;
    idle_pclk(3);
    cam_vsync = 1'b0;
    byte_idx  = 0;
    idle_pclk(2);
  endtask

  task automatic end_frame();
    cam_vsync = 1'b1;
    idle_pclk(3);
  endtask

  task automatic send_frame(input int lines, input int odd_line, input int bpl);
    start_frame();
    for (int l = 0; l < lines; l++) begin
      for (int b = 0; b < ((l == odd_line) ? bpl - 1 : bpl); b++) send_byte();
      idle_pclk(2);
    end
    end_frame();
  endtask

  task automatic test_reset();
    int base;
    int dbase;
    repeat (3) @(negedge clk);
    n_checks++; if (pix_valid !== 1'b0) $display("FAIL rst_pix_valid got %b exp 0", pix_valid); else n_pass++;
    n_checks++; if (pix_data !== 16'h0000) $display("FAIL rst_pix_data got %h exp 0000", pix_data); else n_pass++;
    n_checks++; if (pix_addr !== '0) $display("FAIL rst_pix_addr got %0d exp 0", pix_addr); else n_pass++;
    n_checks++; if (frame_done !== 1'b0) $display("FAIL rst_frame_done got %b exp 0", frame_done); else n_pass++;
    n_checks++; if (frame_err !== 1'b0) $display("FAIL rst_frame_err got %b exp 0", frame_err); else n_pass++;
    n_checks++; if (dbg_state !== ST_IDLE) $display("FAIL rst_state got %0d exp %0d", dbg_state, ST_IDLE); else n_pass++;
    clr = 1'b0;
    repeat (2) @(negedge clk);
    base  = obs_data.size();
    dbase = done_cnt;
    send_frame(2, -1, 8);
    n_checks++; if (obs_data.size() - base !== 0) $display("FAIL noconfig_pixels got %0d exp 0", obs_data.size() - base); else n_pass++;
    n_checks++; if (done_cnt - dbase !== 0) $display("FAIL noconfig_done got %0d exp 0", done_cnt - dbase); else n_pass++;
    n_checks++; if (dbg_state !== ST_IDLE) $display("FAIL noconfig_state got %0d exp %0d", dbg_state, ST_IDLE); else n_pass++;
  endtask

  task automatic test_frame();
    int base;
    int dbase;
    config_finished = 1'b1;
    repeat (4) @(negedge clk);
    base  = obs_data.size();
    dbase = done_cnt;
    exp_q.delete();
    for (int p = 0; p < TB_H * TB_V; p++) exp_q.push_back({byte_at(2 * p), byte_at(2 * p + 1)});
    send_frame(2, -1, 8);
    repeat (10) @(negedge clk);
    n_checks++; if (obs_data.size() - base !== 8) $display("FAIL frame_count got %0d exp 8", obs_data.size() - base); else n_pass++;
    n_checks++; if (done_cnt - dbase !== 1) $display("FAIL frame_done_cnt got %0d exp 1", done_cnt - dbase); else n_pass++;
    n_checks++; if (done_err !== 1'b0) $display("FAIL frame_err got %b exp 0", done_err); else n_pass++;
    if (obs_data.size() - base >= 8) begin
      n_checks++; if (obs_data[base] !== 16'h1234) $display("FAIL first_data got %h exp 1234", obs_data[base]); else n_pass++;
      n_checks++; if (obs_addr[base] !== 3'd0) $display("FAIL first_addr got %0d exp 0", obs_addr[base]); else n_pass++;
      n_checks++; if (obs_data[base+7] !== 16'hEE10) $display("FAIL last_data got %h exp EE10", obs_data[base+7]); else n_pass++;
      n_checks++; if (obs_addr[base+7] !== 3'd7) $display("FAIL last_addr got %0d exp 7", obs_addr[base+7]); else n_pass++;
      n_checks++;
      if (obs_cyc[base] - second_cyc !== TB_SYNC + 2)
        $display("FAIL latency got %0d exp %0d", obs_cyc[base] - second_cyc, TB_SYNC + 2);
      else n_pass++;
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (obs_data[base+i] !== exp_q[i] || obs_addr[base+i] !== TB_ADDR_W'(i))
          $display("FAIL pixel_%0d got %h@%0d exp %h@%0d", i, obs_data[base+i], obs_addr[base+i], exp_q[i], i);
        else n_pass++;
      end
    end
  endtask

  task automatic test_config_mid_frame();
    int base;
    int dbase;
    config_finished = 1'b0;
    repeat (4) @(negedge clk);
    base  = obs_data.size();
    dbase = done_cnt;
    start_frame();
    for (int b = 0; b < 8; b++) send_byte();
    idle_pclk(2);
    for (int b = 0; b < 3; b++) send_byte();
    config_finished = 1'b1;
    for (int b = 0; b < 5; b++) send_byte();
    idle_pclk(2);
    end_frame();
    n_checks++; if (obs_data.size() - base !== 0) $display("FAIL midcfg_ignored got %0d exp 0", obs_data.size() - base); else n_pass++;
    n_checks++; if (done_cnt - dbase !== 0) $display("FAIL midcfg_no_done got %0d exp 0", done_cnt - dbase); else n_pass++;
    n_checks++; if (dbg_state !== ST_WAIT_VS) $display("FAIL midcfg_state got %0d exp %0d", dbg_state, ST_WAIT_VS); else n_pass++;
    send_frame(2, -1, 8);
    repeat (10) @(negedge clk);
    n_checks++; if (obs_data.size() - base !== 8) $display("FAIL midcfg_count got %0d exp 8", obs_data.size() - base); else n_pass++;
    if (obs_data.size() - base > 0) begin
      n_checks++; if (obs_addr[base] !== 3'd0) $display("FAIL midcfg_first_addr got %0d exp 0", obs_addr[base]); else n_pass++;
      n_checks++; if (obs_data[base] !== 16'h1234) $display("FAIL midcfg_first_data got %h exp 1234", obs_data[base]); else n_pass++;
    end
    n_checks++; if (done_err !== 1'b0) $display("FAIL midcfg_err got %b exp 0", done_err); else n_pass++;
  endtask

  task automatic test_odd_line();
    int base;
    int dbase;
    base  = obs_data.size();
    dbase = done_cnt;
    send_frame(2, 0, 8);
    repeat (10) @(negedge clk);
    n_checks++; if (obs_data.size() - base !== 7) $display("FAIL odd_count got %0d exp 7", obs_data.size() - base); else n_pass++;
    if (obs_data.size() - base >= 7) begin
      n_checks++; if (obs_data[base+2] !== 16'h9ABC) $display("FAIL odd_pix2 got %h exp 9ABC", obs_data[base+2]); else n_pass++;
      n_checks++; if (obs_data[base+3] !== 16'h0022) $display("FAIL odd_pix3 got %h exp 0022", obs_data[base+3]); else n_pass++;
      n_checks++; if (obs_addr[base+6] !== 3'd6) $display("FAIL odd_last_addr got %0d exp 6", obs_addr[base+6]); else n_pass++;
    end
    n_checks++; if (done_cnt - dbase !== 1) $display("FAIL odd_done got %0d exp 1", done_cnt - dbase); else n_pass++;
    n_checks++; if (done_err !== 1'b1) $display("FAIL odd_err got %b exp 1", done_err); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int   base;
    logic mid_err;
    base    = obs_data.size();
    mid_err = 1'b0;
    fork
      send_frame(2, -1, 8);
      begin
        repeat (150) @(negedge clk);
        mid_err = frame_err;
      end
    join
    repeat (10) @(negedge clk);
    n_checks++; if (mid_err !== 1'b1) $display("FAIL b2b_err_hold got %b exp 1", mid_err); else n_pass++;
    n_checks++; if (obs_data.size() - base !== 8) $display("FAIL b2b_count got %0d exp 8", obs_data.size() - base); else n_pass++;
    n_checks++; if (frame_err !== 1'b0) $display("FAIL b2b_err got %b exp 0", frame_err); else n_pass++;
  endtask

  task automatic test_saturate();
    int base;
    int dbase;
    base  = obs_data.size();
    dbase = done_cnt;
    send_frame(3, -1, 8);
    repeat (10) @(negedge clk);
    n_checks++; if (obs_data.size() - base !== 8) $display("FAIL sat_count got %0d exp 8", obs_data.size() - base); else n_pass++;
    if (obs_data.size() - base >= 8) begin
      n_checks++; if (obs_addr[base+7] !== 3'd7) $display("FAIL sat_last_addr got %0d exp 7", obs_addr[base+7]); else n_pass++;
      n_checks++; if (obs_data[base+7] !== 16'hEE10) $display("FAIL sat_last_data got %h exp EE10", obs_data[base+7]); else n_pass++;
    end
    n_checks++; if (pix_addr !== 3'd7) $display("FAIL sat_pix_addr got %0d exp 7", pix_addr); else n_pass++;
    n_checks++; if (done_cnt - dbase !== 1) $display("FAIL sat_done got %0d exp 1", done_cnt - dbase); else n_pass++;
    n_checks++; if (done_err !== 1'b1) $display("FAIL sat_err got %b exp 1", done_err); else n_pass++;
  endtask

  task automatic test_clr_mid_line();
    int base;
    int dbase;
    start_frame();
    for (int b = 0; b < 3; b++) send_byte();
    clr = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (pix_data !== 16'h0000) $display("FAIL clr_pix_data got %h exp 0000", pix_data); else n_pass++;
    n_checks++; if (pix_addr !== '0) $display("FAIL clr_pix_addr got %0d exp 0", pix_addr); else n_pass++;
    n_checks++; if (frame_err !== 1'b0) $display("FAIL clr_frame_err got %b exp 0", frame_err); else n_pass++;
    n_checks++; if (dbg_state !== ST_IDLE) $display("FAIL clr_state got %0d exp %0d", dbg_state, ST_IDLE); else n_pass++;
    clr = 1'b0;
    repeat (2) @(negedge clk);
    config_finished = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++; if (dbg_state !== ST_IDLE) $display("FAIL cfgdrop_state got %0d exp %0d", dbg_state, ST_IDLE); else n_pass++;
    config_finished = 1'b1;
    base  = obs_data.size();
    dbase = done_cnt;
    for (int b = 0; b < 5; b++) send_byte();
    idle_pclk(2);
    for (int b = 0; b < 8; b++) send_byte();
    idle_pclk(2);
    end_frame();
    n_checks++; if (obs_data.size() - base !== 0) $display("FAIL clr_rest_ignored got %0d exp 0", obs_data.size() - base); else n_pass++;
    send_frame(2, -1, 8);
    repeat (10) @(negedge clk);
    n_checks++; if (obs_data.size() - base !== 8) $display("FAIL clr_next_count got %0d exp 8", obs_data.size() - base); else n_pass++;
    if (obs_data.size() - base > 0) begin
      n_checks++; if (obs_addr[base] !== 3'd0) $display("FAIL clr_next_addr got %0d exp 0", obs_addr[base]); else n_pass++;
    end
    n_checks++; if (done_cnt - dbase !== 1) $display("FAIL clr_next_done got %0d exp 1", done_cnt - dbase); else n_pass++;
    n_checks++; if (done_err !== 1'b0) $display("FAIL clr_next_err got %b exp 0", done_err); else n_pass++;
  endtask

  initial begin
    clr             = 1'b1;
    config_finished = 1'b0;
    cam_pclk        = 1'b0;
    cam_vsync       = 1'b1;
    cam_href        = 1'b0;
    cam_d           = 8'h00;
    test_reset();
    test_frame();
    test_config_mid_frame();
    test_odd_line();
    test_back_to_back();
    test_saturate();
    test_clr_mid_line();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
